seq_shift_unit: RTL and testbench

Parametrised, multi-cycle shift/rotate unit for the CS-203 ALU datapath. It generalises the fixed single-bit 32-bit shifter to any width, variable shift amount, and five shift/rotate modes. It shifts up to STEP bit positions per clock under a valid/ready handshake. It sits beside the adder and logic units and returns a result, a last-bit-out carry and a zero flag to the ALU output mux.

---
 rtl/shift_pkg.sv | 25 ++
 rtl/shift_step.sv | 71 +++++++
 rtl/seq_shift_unit.sv | 128 ++++++++++++
 tb/tb_seq_shift_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and helpers for the sequential shift/rotate unit.
package shift_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_SLL = 3'd0,
    OP_SRL = 3'd1,
    OP_SRA = 3'd2,
    OP_ROL = 3'd3,
    OP_ROR = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Encodings above ROR pass the operand through untouched
  function automatic logic is_reserved(input logic [OP_W-1:0] op);
    return op > OP_W'(OP_ROR);
  endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational shift/rotate step of k positions (k may be 0).
module shift_step
  import shift_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned STEP  = 1,
  localparam int unsigned KW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [OP_W-1:0]  op,
  input  logic [KW-1:0]    k,
  input  logic             msb_fill,
  output logic [WIDTH-1:0] shifted,
  output logic             out_bit
);

  localparam int unsigned SW = $clog2(WIDTH) + 1;

  logic [SW-1:0]    kx;
  logic [SW-1:0]    kinv;
  logic [WIDTH-1:0] lsh;
  logic [WIDTH-1:0] rsh;
  logic [WIDTH-1:0] wrap_l;
  logic [WIDTH-1:0] wrap_r;
  logic [WIDTH-1:0] fill;
  logic [WIDTH-1:0] right_pick;

  always_comb begin
    kx         = SW'(k);
    kinv       = SW'(WIDTH) - kx;
    lsh        = data << kx;
    rsh        = data >> kx;
    // wrap_l[0] is bit WIDTH-k, the last bit to leave on a left step
    wrap_l     = data >> kinv;
    wrap_r     = data << kinv;
    fill       = msb_fill ? ~({WIDTH{1'b1}} >> kx) : '0;
    right_pick = data >> (kx - SW'(1));

    shifted = data;
    out_bit = 1'b0;
    if (k != '0) begin
      case (op)
        OP_SLL: begin
          shifted = lsh;
          out_bit = wrap_l[0];
        end
        OP_SRL: begin
          shifted = rsh;
          out_bit = right_pick[0];
        end
        OP_SRA: begin
          shifted = rsh | fill;
          out_bit = right_pick[0];
        end
        OP_ROL: begin
          shifted = lsh | wrap_l;
          out_bit = wrap_l[0];
        end
        OP_ROR: begin
          shifted = rsh | wrap_r;
          out_bit = right_pick[0];
        end
        default: begin
          shifted = data;
          out_bit = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate unit: up to STEP positions per clock, valid/ready on both sides.
module seq_shift_unit
  import shift_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned STEP  = 1,
  localparam int unsigned AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [AW-1:0]    amt,
  input  logic [WIDTH-1:0] a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  localparam int unsigned KW = $clog2(STEP + 1);
  localparam int unsigned RW = AW + 1;

  state_e           state;
  state_e           state_nx;
  logic [AW-1:0]    remaining;
  logic [OP_W-1:0]  op_q;
  logic             msb_q;

  logic [KW-1:0]    k_c;
  logic [AW-1:0]    rem_nx_c;
  logic [WIDTH-1:0] step_data_c;
  logic             step_bit_c;
  logic             load_c;
  logic             shift_c;
  logic             in_ready_d_c;
  logic             out_valid_d_c;

  // Step size: the full STEP, or whatever is left on the final step
  always_comb begin
    if ({1'b0, remaining} >= RW'(STEP)) k_c = KW'(STEP);
    else                                k_c = KW'(remaining);
    rem_nx_c = remaining - AW'(k_c);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .data     (result),
    .op       (op_q),
    .k        (k_c),
    .msb_fill (msb_q),
    .shifted  (step_data_c),
    .out_bit  (step_bit_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          if (amt == '0 || is_reserved(op)) state_nx = ST_DONE;
          else                               state_nx = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (rem_nx_c == '0) state_nx = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    load_c        = 1'b0;
    shift_c       = 1'b0;
    in_ready_d_c  = (state_nx == ST_IDLE);
    out_valid_d_c = (state_nx == ST_DONE);
    if (state == ST_IDLE && in_valid) load_c  = 1'b1;
    if (state == ST_SHIFT)            shift_c = 1'b1;
  end

  // Handshake flags follow the next state so they line up with the state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= in_ready_d_c;
      out_valid <= out_valid_d_c;
    end
  end

  // Working register doubles as the result; it only moves on accept or shift edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      carry     <= 1'b0;
      zero      <= 1'b1;
      remaining <= '0;
      op_q      <= OP_W'(OP_SLL);
      msb_q     <= 1'b0;
    end else if (load_c) begin
      result    <= a;
      carry     <= 1'b0;
      zero      <= (a == '0);
      remaining <= is_reserved(op) ? '0 : amt;
      op_q      <= op;
      msb_q     <= a[WIDTH-1];
    end else if (shift_c) begin
      result    <= step_data_c;
      carry     <= step_bit_c;
      zero      <= (step_data_c == '0);
      remaining <= rem_nx_c;
    end
  end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Scoreboard bench for seq_shift_unit: STEP=1 main instance plus a STEP=8 instance.
module tb_seq_shift_unit;
  import shift_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  op;
  logic [4:0]  amt;
  logic [31:0] a, result;
  logic        carry, zero;

  logic        f_in_valid, f_in_ready, f_out_valid, f_out_ready;
  logic [2:0]  f_op;
  logic [4:0]  f_amt;
  logic [31:0] f_a, f_result;
  logic        f_carry, f_zero;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] res;
    logic        c;
    logic        z;
    int          lat;
    int          acc;
  } exp_t;
  exp_t q[$];

  seq_shift_unit #(.WIDTH(32), .STEP(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .amt(amt), .a(a), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .zero(zero)
  );

  seq_shift_unit #(.WIDTH(32), .STEP(8)) u_fast (
    .clk(clk), .rst_n(rst_n), .in_valid(f_in_valid), .in_ready(f_in_ready),
    .op(f_op), .amt(f_amt), .a(f_a), .out_valid(f_out_valid), .out_ready(f_out_ready),
    .result(f_result), .carry(f_carry), .zero(f_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // Present a request until accepted; push its hand-computed response
  task automatic send(input logic [2:0] o, input logic [31:0] av, input logic [4:0] am,
                      input logic [31:0] er, input logic ec, input int el);
    exp_t e;
    bit   done;
    done = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; op = o; a = av; amt = am;
    for (int n = 0; n < 300 && !done; n++) begin
      if (in_ready) begin
        e.res = er; e.c = ec; e.z = (er == 32'h0); e.lat = el; e.acc = cyc + 1;
        q.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL accept_timeout: op %0d a %h never accepted", o, av);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 2000 && q.size() != 0; n++) @(negedge clk);
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d results outstanding", q.size());
      q.delete();
    end
  endtask

  // Monitor: compare every cycle a result is presented, pop on retirement
  initial begin
    bit seen;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 1'b0;
      end else if (out_valid) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_valid: result %h with nothing outstanding", result);
        end else begin
          if (!seen) begin
            seen = 1'b1;
            chk("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
          end
          chk("result", result, q[0].res);
          chk("carry", 32'(carry), 32'(q[0].c));
          chk("zero", 32'(zero), 32'(q[0].z));
          chk("in_ready_low_in_done", 32'(in_ready), 32'd0);
          if (out_ready) begin
            void'(q.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic run_fast(input logic [2:0] o, input logic [31:0] av, input logic [4:0] am,
                          input logic [31:0] er, input logic ec, input int el);
    int lat;
    bit got;
    @(negedge clk);
    chk("f_in_ready", 32'(f_in_ready), 32'd1);
    f_in_valid = 1'b1; f_op = o; f_a = av; f_amt = am;
    @(posedge clk);
    #1 f_in_valid = 1'b0;
    got = 1'b0; lat = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (f_out_valid) begin got = 1'b1; lat = i; end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL f_timeout: no result for op %0d a %h", o, av);
    end else begin
      chk("f_latency", 32'(lat), 32'(el));
      chk("f_result", f_result, er);
      chk("f_carry", 32'(f_carry), 32'(ec));
      chk("f_zero", 32'(f_zero), 32'(er == 32'h0));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit vld;
    rst_n = 1'b0; in_valid = 1'b0; op = '0; amt = '0; a = '0; out_ready = 1'b1;
    f_in_valid = 1'b0; f_op = '0; f_amt = '0; f_a = '0; f_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_carry", 32'(carry), 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    rst_n = 1'b1;

    send(OP_SLL, 32'h8000_0001, 5'd1,  32'h0000_0002, 1'b1, 1);
    send(OP_SRA, 32'h8000_00F0, 5'd4,  32'hF800_000F, 1'b0, 4);
    send(OP_ROR, 32'h0000_0001, 5'd31, 32'h0000_0002, 1'b0, 31);
    send(OP_SRL, 32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0, 0);
    send(3'b110, 32'h1234_5678, 5'd5,  32'h1234_5678, 1'b0, 0);
    send(OP_ROL, 32'h8000_0000, 5'd1,  32'h0000_0001, 1'b1, 1);
    send(OP_SRA, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 1'b1, 31);
    send(OP_SLL, 32'h0000_0000, 5'd0,  32'h0000_0000, 1'b0, 0);
    drain();

    // Backpressure: hold out_ready low for 5 cycles while a second request waits
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(OP_SLL, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 31);
    fork
      send(OP_ROL, 32'h1234_5678, 5'd4, 32'h2345_6781, 1'b1, 4);
      begin
        vld = 1'b0;
        for (int n = 0; n < 100 && !vld; n++) begin
          @(negedge clk);
          vld = out_valid;
        end
        chk("bp_valid_seen", 32'(vld), 32'd1);
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset in the middle of a shift: abandon it, then a fresh request must complete
    @(negedge clk);
    chk("pre_abort_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; op = OP_SRL; a = 32'hFFFF_FFFF; amt = 5'd20;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_result", result, 32'h0);
    chk("abort_carry", 32'(carry), 32'd0);
    chk("abort_zero", 32'(zero), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    send(OP_SRL, 32'hFFFF_FFFF, 5'd20, 32'h0000_0FFF, 1'b1, 20);
    drain();

    // STEP=8 instance: same results, fewer shift cycles
    run_fast(OP_ROR, 32'h0000_0001, 5'd31, 32'h0000_0002, 1'b0, 4);
    run_fast(OP_SRA, 32'h8000_00F0, 5'd4,  32'hF800_000F, 1'b0, 1);
    run_fast(OP_SRL, 32'hFFFF_FFFF, 5'd20, 32'h0000_0FFF, 1'b1, 3);
    run_fast(OP_SLL, 32'h8000_0001, 5'd0,  32'h8000_0001, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
